// File: rtl/conv_window_ctrl.sv
// Streaming 3x3 window controller for the Sobel-X datapath: line buffers, window shift register and a result register.
// Optional define ABS_OUT_EN makes the result register load |conv_res| instead of signed conv_res.
module conv_window_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [71:0] win,
    input  logic [10:0] conv_res,
    output logic [10:0] res_out,
    output logic        res_valid,
    input  logic        res_ready
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t          state_q, state_d;
    logic            done_q, done_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [71:0]     win_q, win_d;
    logic            wValid_q, wValid_d;
    logic [10:0]     res_q, res_d;
    logic            resValid_q, resValid_d;

    logic [7:0]      lineA [IMG_W];
    logic [7:0]      lineB [IMG_W];
    logic [7:0]      rdA, rdB;
    logic            accept, load, lastPix;
    logic [10:0]     resLoad;

    assign accept  = pix_valid && pix_ready;
    assign load    = wValid_q && (!resValid_q || res_ready);
    assign lastPix = (col_q == CW'(IMG_W - 1)) && (row_q == RW'(IMG_H - 1));
    assign rdA     = lineA[col_q];
    assign rdB     = lineB[col_q];

`ifdef ABS_OUT_EN
    assign resLoad = conv_res[10] ? (~conv_res + 11'd1) : conv_res;
`else
    assign resLoad = conv_res;
`endif

    // lineA holds row r-1, lineB row r-2; the displaced r-1 pixel ages into lineB
    always_ff @(posedge clk) begin
        if (accept) begin
            lineA[col_q] <= pix_in;
            lineB[col_q] <= rdA;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (accept && lastPix) state_d = DRAIN;
            DRAIN: begin
                if (!wValid_q && (!resValid_q || res_ready)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        pix_ready = (state_q == RUN) && (!wValid_q || !resValid_q || res_ready);
    end

    // Window shifts left; the new right-hand column is {r-2, r-1, current}
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        win_d      = win_q;
        wValid_d   = wValid_q;
        res_d      = res_q;
        resValid_d = resValid_q;
        if (state_q == IDLE && start) begin
            col_d = '0;
            row_d = '0;
        end
        if (accept) begin
            win_d    = {win_q[63:48], rdB, win_q[39:24], rdA, win_q[15:0], pix_in};
            wValid_d = (row_q >= RW'(2)) && (col_q >= CW'(2));
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end else if (load) begin
            wValid_d = 1'b0;
        end
        if (load) begin
            res_d      = resLoad;
            resValid_d = 1'b1;
        end else if (res_ready) begin
            resValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q      <= '0;
            row_q      <= '0;
            win_q      <= '0;
            wValid_q   <= 1'b0;
            res_q      <= '0;
            resValid_q <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            win_q      <= win_d;
            wValid_q   <= wValid_d;
            res_q      <= res_d;
            resValid_q <= resValid_d;
        end
    end

    assign win       = win_q;
    assign res_out   = res_q;
    assign res_valid = resValid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Scoreboard bench for conv_window_ctrl: a 5x4 instance for the frame tests and a 3x3 instance for latency.
// The Sobel-X block is modelled here; expected results come from the bench's own copy of each image.
module tb_conv_window_ctrl;

    localparam int WA = 5;
    localparam int HA = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic        startA = 1'b0, pixValidA = 1'b0, resReadyA = 1'b1;
    logic [7:0]  pixInA = 8'd0;
    logic        busyA, doneA, pixReadyA, resValidA;
    logic [71:0] winA;
    logic [10:0] convA, resOutA;

    logic        startB = 1'b0, pixValidB = 1'b0, resReadyB = 1'b1;
    logic [7:0]  pixInB = 8'd0;
    logic        busyB, doneB, pixReadyB, resValidB;
    logic [71:0] winB;
    logic [10:0] convB, resOutB;

    int stallMode = 0;

    function automatic logic [10:0] sobel(input logic [71:0] w);
        int p [9];
        int s;
        for (int i = 0; i < 9; i++) p[i] = int'(w[71 - 8*i -: 8]);
        s = p[0] - p[2] + 2*p[3] - 2*p[5] + p[6] - p[8];
        return 11'(s);
    endfunction

    assign convA = sobel(winA);
    assign convB = sobel(winB);

    conv_window_ctrl #(.IMG_W(WA), .IMG_H(HA)) dutA (
        .clk(clk), .rst(rst), .start(startA), .busy(busyA), .done(doneA),
        .pix_in(pixInA), .pix_valid(pixValidA), .pix_ready(pixReadyA),
        .win(winA), .conv_res(convA), .res_out(resOutA),
        .res_valid(resValidA), .res_ready(resReadyA)
    );

    conv_window_ctrl #(.IMG_W(3), .IMG_H(3)) dutB (
        .clk(clk), .rst(rst), .start(startB), .busy(busyB), .done(doneB),
        .pix_in(pixInB), .pix_valid(pixValidB), .pix_ready(pixReadyB),
        .win(winB), .conv_res(convB), .res_out(resOutB),
        .res_valid(resValidB), .res_ready(resReadyB)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [71:0] actual, input logic [71:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Bench-side expectation from the stored image, independent of the window register
    int imgA [HA][WA];

    function automatic logic [10:0] expectedA(input int r, input int c);
        int s;
        s = imgA[r-2][c-2] - imgA[r-2][c] + 2*(imgA[r-1][c-2] - imgA[r-1][c])
            + imgA[r][c-2] - imgA[r][c];
`ifdef ABS_OUT_EN
        if (s < 0) s = -s;
`endif
        return 11'(s);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            resReadyA = (stallMode == 0) ? 1'b1 : ((cyc % 3) == 0);
        end
    end

    logic [10:0] expQ [$];
    int          mRow = 0, mCol = 0;
    int          resCntA = 0, doneCntA = 0, lastHs = 0;
    logic        pendAcc = 1'b0, stalled = 1'b0;
    logic [7:0]  pendPix = 8'd0;
    logic [10:0] heldVal = 11'd0;

    // Monitor for dutA: commits the accept seen last cycle, then checks this cycle's outputs
    always @(negedge clk) begin
        if (pendAcc) begin
            imgA[mRow][mCol] = int'(pendPix);
            if (mRow >= 2 && mCol >= 2) expQ.push_back(expectedA(mRow, mCol));
            if (mCol == WA - 1) begin
                mCol = 0;
                mRow = (mRow == HA - 1) ? 0 : mRow + 1;
            end else begin
                mCol++;
            end
            pendAcc = 1'b0;
        end
        if (rst) begin
            expQ.delete();
            mRow = 0; mCol = 0; resCntA = 0;
            stalled = 1'b0;
        end else begin
            if (startA && !busyA) begin
                mRow = 0; mCol = 0; resCntA = 0; doneCntA = 0;
            end
            if (stalled) begin
                checkOutput("stallValid", 72'(resValidA), 72'd1);
                checkOutput("stallHold", 72'(resOutA), 72'(heldVal));
            end
            stalled = resValidA && !resReadyA;
            heldVal = resOutA;
            if (expQ.size() >= 2 && resValidA && !resReadyA)
                checkOutput("readyLowFull", 72'(pixReadyA), 72'd0);
            if (resValidA && resReadyA) begin
                if (expQ.size() == 0) checkOutput("unexpectedResult", 72'd1, 72'd0);
                else checkOutput("result", 72'(resOutA), 72'(expQ.pop_front()));
                resCntA++;
                lastHs = cyc;
            end
            if (doneA) begin
                doneCntA++;
                checkOutput("doneTiming", 72'(cyc), 72'(lastHs + 1));
                checkOutput("resultCount", 72'(resCntA), 72'((WA-2)*(HA-2)));
                checkOutput("busyAtDone", 72'(busyA), 72'd0);
            end
            if (pixValidA && pixReadyA) begin
                pendAcc = 1'b1;
                pendPix = pixInA;
            end
        end
    end

    int   accB = 0, accCycB = 0, resCntB = 0, doneCntB = 0;
    logic seenB = 1'b0;
    logic [10:0] expB;

    initial begin
        int s;
        s = (1 + 2*4 + 7) - (3 + 2*6 + 9);
`ifdef ABS_OUT_EN
        if (s < 0) s = -s;
`endif
        expB = 11'(s);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (pixValidB && pixReadyB) begin
                accB++;
                if (accB == 9) accCycB = cyc;
            end
            if (resValidB && !seenB) begin
                seenB = 1'b1;
                checkOutput("latency3x3", 72'(cyc - accCycB), 72'd2);
            end
            if (resValidB && resReadyB) begin
                resCntB++;
                checkOutput("result3x3", 72'(resOutB), 72'(expB));
            end
            if (doneB) doneCntB++;
        end
    end

    task automatic applyStimulus(input int pattern, input int stall, input int randValid, input int midStart);
        int   pix [WA*HA];
        int   k, budget;
        logic acc;
        logic injected;
        for (int r = 0; r < HA; r++)
            for (int c = 0; c < WA; c++)
                case (pattern)
                    0:       pix[r*WA + c] = 77;
                    1:       pix[r*WA + c] = (c < 2) ? 0 : 100;
                    2:       pix[r*WA + c] = 0;
                    default: pix[r*WA + c] = int'($urandom_range(0, 255));
                endcase
        stallMode = stall;
        startA = 1'b1;
        @(posedge clk); #1;
        startA = 1'b0;
        k = 0; budget = 0; injected = 1'b0;
        while (k < WA*HA && budget < 1000) begin
            pixInA = 8'(pix[k]);
            pixValidA = (randValid != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (midStart != 0 && k == 7 && !injected) begin
                startA = 1'b1;
                injected = 1'b1;
            end else begin
                startA = 1'b0;
            end
            @(negedge clk);
            acc = pixValidA && pixReadyA;
            @(posedge clk); #1;
            if (acc) k++;
            budget++;
        end
        pixValidA = 1'b0;
        startA = 1'b0;
        if (k < WA*HA) checkOutput("pixelTimeout", 72'(k), 72'(WA*HA));
        budget = 0;
        while (doneCntA == 0 && budget < 300) begin
            @(posedge clk); #1;
            budget++;
        end
        if (doneCntA == 0) checkOutput("doneTimeout", 72'd0, 72'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("donePulses", 72'(doneCntA), 72'd1);
        checkOutput("doneLow", 72'(doneA), 72'd0);
        checkOutput("busyIdle", 72'(busyA), 72'd0);
        stallMode = 0;
    endtask

    initial begin
        int   k, budget;
        logic acc;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstBusy", 72'(busyA), 72'd0);
        checkOutput("rstDone", 72'(doneA), 72'd0);
        checkOutput("rstPixReady", 72'(pixReadyA), 72'd0);
        checkOutput("rstWin", winA, 72'd0);
        checkOutput("rstResOut", 72'(resOutA), 72'd0);
        checkOutput("rstResValid", 72'(resValidA), 72'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 1, 1, 0);
        applyStimulus(3, 0, 0, 1);

        // Abort a frame after 9 accepted pixels
        startA = 1'b1;
        @(posedge clk); #1;
        startA = 1'b0;
        k = 0; budget = 0;
        while (k < 9 && budget < 200) begin
            pixInA = 8'd50;
            pixValidA = 1'b1;
            @(negedge clk);
            acc = pixReadyA;
            @(posedge clk); #1;
            if (acc) k++;
            budget++;
        end
        if (k < 9) checkOutput("abortTimeout", 72'(k), 72'd9);
        rst = 1'b1;
        pixValidA = 1'b0;
        #1;
        checkOutput("midRstResValid", 72'(resValidA), 72'd0);
        checkOutput("midRstBusy", 72'(busyA), 72'd0);
        checkOutput("midRstPixReady", 72'(pixReadyA), 72'd0);
        checkOutput("midRstWin", winA, 72'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(2, 0, 0, 0);

        startB = 1'b1;
        @(posedge clk); #1;
        startB = 1'b0;
        k = 0; budget = 0;
        while (k < 9 && budget < 200) begin
            pixInB = 8'(k + 1);
            pixValidB = 1'b1;
            @(negedge clk);
            acc = pixReadyB;
            @(posedge clk); #1;
            if (acc) k++;
            budget++;
        end
        pixValidB = 1'b0;
        if (k < 9) checkOutput("pixelTimeout3x3", 72'(k), 72'd9);
        budget = 0;
        while (doneCntB == 0 && budget < 50) begin
            @(posedge clk); #1;
            budget++;
        end
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resultCount3x3", 72'(resCntB), 72'd1);
        checkOutput("donePulses3x3", 72'(doneCntB), 72'd1);
        checkOutput("busyIdle3x3", 72'(busyB), 72'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/conv_window_ctrl.md
# conv_window_ctrl

Streaming controller for the 3x3 Sobel-X convolution datapath. It accepts a raster-order 8-bit grayscale pixel stream and buffers two image rows in line memories. For every interior pixel position it assembles the 72-bit 3x3 window and drives it to the combinational convolution block. It then registers that block's 11-bit signed result and returns it through a valid/ready output stream, with frame start/done sequencing.

## Interface
Parameters:
- IMG_W, 640, image width in pixels (3..1024)
- IMG_H, 480, image height in rows (3..1024)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle frame start; honoured only in IDLE
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse on DRAIN->IDLE
- pix_in  in  8  input pixel
- pix_valid  in  1  pixel present
- pix_ready  out  1  pixel accepted when pix_valid && pix_ready
- win  out  72  window to convolution; [71:64]=top-left … [7:0]=bottom-right, row-major
- conv_res  in  11  signed result from convolution, combinational from win
- res_out  out  11  registered result
- res_valid  out  1  result present
- res_ready  in  1  result consumed when res_valid && res_ready

## Operation
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) track the position of the next accepted pixel. col wraps to 0 and row increments after col=IMG_W-1.
- Two IMG_W x 8 line buffers hold rows r-1 and r-2. On accept at column c: read both buffers at c, write pix_in into the r-1 buffer and the old r-1 value into the r-2 buffer.
- The 3x3 window register shifts left one column per accept, taking the new column {r-2, r-1, pix_in}.
- Stage 1 (w_valid): set on an accept with row>=2 and col>=2; otherwise cleared when stage 2 loads.
- Stage 2: loads res_out<=conv_res, res_valid<=1 when w_valid && (!res_valid || res_ready). res_valid clears on a handshake with no new load.
- pix_ready = (state==RUN) && (!w_valid || !res_valid || res_ready).
- Each frame yields exactly (IMG_W-2)*(IMG_H-2) results in raster order.
- The window register is not cleared at row wrap. Results only emit for col>=2, so stale columns never appear.

State machine:
- IDLE: pix_ready=0. On start: zero the counters, go to RUN.
- RUN: accept pixels. On accepting (IMG_H-1, IMG_W-1), go to DRAIN.
- DRAIN: pix_ready=0. When w_valid=0 and (res_valid=0 or a handshake occurs this cycle), go to IDLE and pulse done.
- start in RUN/DRAIN is ignored.

## Timing
- Reset values: busy=0, done=0, pix_ready=0, win=0, res_out=0, res_valid=0, state IDLE, counters 0. Line buffer contents are don't-care.
- Latency: a pixel accepted at edge T completing a window updates win after T. res_valid rises after edge T+1, i.e. 2 clocks accept-to-result, with no output stall.
- Throughput: 1 pixel/clock when res_ready is held high.
- Backpressure: res_valid && !res_ready holds res_out stable. A pending w_valid then holds win stable and deasserts pix_ready. No result is lost or duplicated.
- done asserts exactly 1 cycle, in the cycle after the last result's handshake.
- rst mid-frame: immediate return to reset values; the partial frame is discarded. A new frame needs start.
- Result arithmetic: conv_res is the plain 11-bit signed kernel sum [1 0 -1; 2 0 -2; 1 0 -1], range ±1020; passed through unmodified.

## Configuration
- ABS_OUT_EN defined: stage 2 loads |conv_res| (11-bit, always non-negative, max 1020) to give gradient magnitude.
- ABS_OUT_EN undefined: stage 2 loads conv_res as a signed value.
- No other behaviour differs.

## Test plan
- IMG_W=5, IMG_H=4, uniform pixel 77, res_ready=1 -> exactly 6 results, all 0; done pulses once, 1 cycle after the 6th handshake; busy low afterwards.
- IMG_W=5, IMG_H=4, columns 0-1 = 0, columns 2-4 = 100 -> per row, results -400, -400, 0. Without ABS_OUT_EN res_out=11'h670; with ABS_OUT_EN res_out=400.
- Same image, res_ready toggled 1-of-3 cycles and pix_valid random -> identical result sequence; res_out stable while stalled; pix_ready low while both stages are full.
- Pulse start during RUN -> ignored; counters and result count are unaffected.
- Assert rst after 9 accepted pixels, then start a fresh uniform-0 frame -> res_valid=0 immediately on rst, and the next frame gives exactly 6 zero results.
- IMG_W=3, IMG_H=3, pixels 1..9 -> a single result, (1+8+7)-(3+12+9) = -8, at 2 clocks after the 9th accept.
